// File: rtl/noc_pm_fifo_endpoint_if.sv
// Bundles the NoC-side valid/ready streams and the PM-side async FIFO pointer/data
// links of the NoC-domain FIFO endpoint; master is the endpoint, slave is its environment.
interface noc_pm_fifo_endpoint_if #(
  parameter int unsigned AWIDTH      = 3,
  parameter int unsigned PACKET_SIZE = 85
);
  logic [PACKET_SIZE-1:0] noc_in_data_i;
  logic                   noc_in_valid_i;
  logic                   noc_in_ready_o;
  logic [PACKET_SIZE-1:0] noc_out_data_o;
  logic                   noc_out_valid_o;
  logic                   noc_out_ready_i;
  logic [PACKET_SIZE-1:0] noc_fifo_pm_in_data_o;
  logic [AWIDTH:0]        noc_fifo_pm_in_raddr_i;
  logic [AWIDTH:0]        noc_fifo_pm_in_waddr_o;
  logic [PACKET_SIZE-1:0] noc_fifo_pm_out_data_i;
  logic [AWIDTH:0]        noc_fifo_pm_out_raddr_o;
  logic [AWIDTH:0]        noc_fifo_pm_out_waddr_i;

  modport master (
    input  noc_in_data_i, noc_in_valid_i, noc_out_ready_i,
    input  noc_fifo_pm_in_raddr_i, noc_fifo_pm_out_data_i, noc_fifo_pm_out_waddr_i,
    output noc_in_ready_o, noc_out_data_o, noc_out_valid_o,
    output noc_fifo_pm_in_data_o, noc_fifo_pm_in_waddr_o, noc_fifo_pm_out_raddr_o
  );

  modport slave (
    output noc_in_data_i, noc_in_valid_i, noc_out_ready_i,
    output noc_fifo_pm_in_raddr_i, noc_fifo_pm_out_data_i, noc_fifo_pm_out_waddr_i,
    input  noc_in_ready_o, noc_out_data_o, noc_out_valid_o,
    input  noc_fifo_pm_in_data_o, noc_fifo_pm_in_waddr_o, noc_fifo_pm_out_raddr_o
  );
endinterface

// File: rtl/noc_pm_fifo_endpoint.sv
// NoC-domain end of the NoC<->PM async FIFO pair: owns the PM-inbound storage (writer)
// and drains the PM-outbound FIFO (reader) through a one-entry registered output stage.
module noc_pm_fifo_endpoint #(
  parameter int unsigned NOC_ASYNC_FIFO_AWIDTH      = 3,
  parameter int unsigned NOC_ASYNC_FIFO_PACKET_SIZE = 85
) (
  input logic clk_noc_i,
  input logic reset_noc_i,
  noc_pm_fifo_endpoint_if.master bus
);
  localparam int unsigned AW    = NOC_ASYNC_FIFO_AWIDTH;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DW    = NOC_ASYNC_FIFO_PACKET_SIZE;
  localparam int unsigned DEPTH = 1 << AW;

  typedef logic [PW-1:0] ptr_t;

  // Top two Gray bits inverted marks a write pointer one full lap ahead of the reader.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (PW - 2);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Low AW bits of gray2bin(g): binary bit i is the XOR of Gray bits i..MSB.
  function automatic logic [AW-1:0] gray2idx(input ptr_t g);
    logic [AW-1:0] idx;
    for (int i = 0; i < int'(AW); i++) begin
      idx[i] = ^(g >> i);
    end
    return idx;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  ptr_t wbin, wgray, rsync_q1, rsync;
  ptr_t rbin, rgray, wsync_q1, wsync;
  logic full, empty, push, pop;
  logic          out_valid;
  logic [DW-1:0] out_data;

  assign full  = (wgray == (rsync ^ FULL_MASK));
  assign empty = (rgray == wsync);
  assign push  = bus.noc_in_valid_i && !full;
  assign pop   = !empty && (!out_valid || bus.noc_out_ready_i);

  assign bus.noc_in_ready_o          = !full;
  assign bus.noc_fifo_pm_in_waddr_o  = wgray;
  assign bus.noc_fifo_pm_out_raddr_o = rgray;
  assign bus.noc_out_valid_o         = out_valid;
  assign bus.noc_out_data_o          = out_data;

  // Read port for the PM domain: a pure mux on its own pointer (timing false path).
  assign bus.noc_fifo_pm_in_data_o = mem[gray2idx(bus.noc_fifo_pm_in_raddr_i)];

  // Two-flop synchronizers: the only points sampling the remote domain.
  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      rsync_q1 <= '0;
      rsync    <= '0;
      wsync_q1 <= '0;
      wsync    <= '0;
    end else begin
      rsync_q1 <= bus.noc_fifo_pm_in_raddr_i;
      rsync    <= rsync_q1;
      wsync_q1 <= bus.noc_fifo_pm_out_waddr_i;
      wsync    <= wsync_q1;
    end
  end

  // Entry and pointer update on the same edge, so data is stable before the pointer is visible.
  always_ff @(posedge clk_noc_i) begin
    if (!reset_noc_i && push) begin
      mem[wbin[AW-1:0]] <= bus.noc_in_data_i;
    end
  end

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      wbin  <= '0;
      wgray <= '0;
    end else if (push) begin
      wbin  <= wbin + ptr_t'(1);
      wgray <= bin2gray(wbin + ptr_t'(1));
    end
  end

  // Outbound drain into a one-entry output register; refills in the cycle it is accepted.
  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      rbin      <= '0;
      rgray     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      rbin      <= rbin + ptr_t'(1);
      rgray     <= bin2gray(rbin + ptr_t'(1));
      out_valid <= 1'b1;
      out_data  <= bus.noc_fifo_pm_out_data_i;
    end else if (bus.noc_out_ready_i) begin
      out_valid <= 1'b0;
    end
  end
endmodule
